// File: rtl/tpm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpm_pkg
//  Description : Shared constants and types for the per-bank port arbiters.
//                NUM_PORTS requesting ports share each single-ported bank.
//                The bank read latency is one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
package tpm_pkg;

    localparam int NUM_PORTS   = 3;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 16;
    localparam int TAG_W       = 2;
    localparam int BANK_ID_W   = 2;
    localparam int BANK_RD_LAT = 1;

    // One masked port request as seen by a bank arbiter.
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } port_req_t;

endpackage : tpm_pkg
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter3
//  Description : Combinational three-way round-robin grant. The search starts
//                at port index ptr and wraps modulo 3; the first requesting
//                port wins. The grant is one-hot, or zero with no request.
//  Ports       : req   [2:0] in  - request vector, bit i = port i
//                ptr   [1:0] in  - index of the highest-priority port
//                grant [2:0] out - one-hot grant
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd2: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            // ptr == 3 is never produced by the owners; treat it like 0.
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule : rr_arbiter3
`default_nettype wire

// File: rtl/bank_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bank_port_arbiter
//  Description : Per-bank scheduler between three port requests and one
//                single-ported memory bank. Grants at most one request per
//                cycle (round robin), issues the bank command one cycle after
//                acceptance and returns the response two cycles after
//                acceptance, tagged with the originating port and tag.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                req_valid/wen/addr/wdata/tag - per-port requests (slice i)
//                req_ready                  - one-hot combinational accept
//                bank_en/wen/addr/wdata     - registered bank command
//                bank_rdata                 - bank data, one cycle after en
//                resp_valid/port/wen/tag/rdata - response to the port
//                stats_clr, conflict_cnt    - only with BANK_ARB_STATS_EN
//  Options     : `define BANK_ARB_STATS_EN adds a saturating 16-bit counter of
//                cycles with two or more concurrent requests.
//  Revision    : 1.0  initial release
// ============================================================================
module bank_port_arbiter
    import tpm_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wen,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS*TAG_W-1:0]  req_tag,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic                        bank_en,
    output logic                        bank_wen,
    output logic [ADDR_W-1:0]           bank_addr,
    output logic [DATA_W-1:0]           bank_wdata,
    input  logic [DATA_W-1:0]           bank_rdata,
    output logic                        resp_valid,
    output logic [NUM_PORTS-1:0]        resp_port,
    output logic                        resp_wen,
    output logic [TAG_W-1:0]            resp_tag,
    output logic [DATA_W-1:0]           resp_rdata
`ifdef BANK_ARB_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [15:0]                 conflict_cnt
`endif
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0]           r_ptr;
    logic [1:0]           w_ptr_nxt;
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_accept;

    rr_arbiter3 u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    // The grant is non-zero exactly when some port is valid, so any valid
    // request implies an accept this cycle.
    assign req_ready = w_grant;
    assign w_accept  = |w_grant;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_grant[0]) w_ptr_nxt = 2'd1;
        if (w_grant[1]) w_ptr_nxt = 2'd2;
        if (w_grant[2]) w_ptr_nxt = 2'd0;
    end

    // Winner field selection; grant is one-hot so at most one slice is taken.
    logic              w_sel_wen;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [TAG_W-1:0]  w_sel_tag;

    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_tag   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                w_sel_wen   = req_wen[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_tag   = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: bank command plus the return routing for the response
    // ------------------------------------------------------------------
    logic                 r_bank_en;
    logic                 r_bank_wen;
    logic [ADDR_W-1:0]    r_bank_addr;
    logic [DATA_W-1:0]    r_bank_wdata;
    logic [NUM_PORTS-1:0] r_s1_port;
    logic [TAG_W-1:0]     r_s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= 2'd0;
            r_bank_en    <= 1'b0;
            r_bank_wen   <= 1'b0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_s1_port    <= '0;
            r_s1_tag     <= '0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_bank_en <= w_accept;
            // Command fields hold across idle cycles.
            if (w_accept) begin
                r_bank_wen   <= w_sel_wen;
                r_bank_addr  <= w_sel_addr;
                r_bank_wdata <= w_sel_wdata;
                r_s1_port    <= w_grant;
                r_s1_tag     <= w_sel_tag;
            end
        end
    end

    assign bank_en    = r_bank_en;
    assign bank_wen   = r_bank_wen;
    assign bank_addr  = r_bank_addr;
    assign bank_wdata = r_bank_wdata;

    // ------------------------------------------------------------------
    // Stage 2: response, aligned with the bank read data
    // ------------------------------------------------------------------
    logic                 r_resp_valid;
    logic [NUM_PORTS-1:0] r_resp_port;
    logic                 r_resp_wen;
    logic [TAG_W-1:0]     r_resp_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_port  <= '0;
            r_resp_wen   <= 1'b0;
            r_resp_tag   <= '0;
        end else begin
            r_resp_valid <= r_bank_en;
            if (r_bank_en) begin
                r_resp_port <= r_s1_port;
                r_resp_wen  <= r_bank_wen;
                r_resp_tag  <= r_s1_tag;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_port  = r_resp_port;
    assign resp_wen   = r_resp_wen;
    assign resp_tag   = r_resp_tag;
    // Read data passes straight through from the bank; writes and idle
    // cycles return zero.
    assign resp_rdata = (r_resp_valid && !r_resp_wen) ? bank_rdata : '0;

`ifdef BANK_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Conflict statistics
    // ------------------------------------------------------------------
    logic [15:0] r_conflict_cnt;
    logic        w_multi_req;

    assign w_multi_req = (req_valid[0] & req_valid[1]) |
                         (req_valid[0] & req_valid[2]) |
                         (req_valid[1] & req_valid[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (stats_clr) begin
            r_conflict_cnt <= '0;
        end else if (w_multi_req && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule : bank_port_arbiter
`default_nettype wire

// File: doc/bank_port_arbiter.md
Name: bank_port_arbiter

Overview:
- Per-bank scheduler between the three masked port requests and one single-ported memory bank (one instance per bank, four banks).
- Each cycle it grants at most one of up to three concurrent requests, using round-robin priority.
- It drives the bank command, tracks the in-flight access, and returns the response to the originating port with its request tag.
- Losers are stalled through per-port ready.

Parameters:
- ADDR_W, 10, bank-local word address width
- DATA_W, 16, data width
- TAG_W, 2, request tag width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  3  per-port request valid, bit i = port i+1, from masking stage
- req_wen  input  3  per-port write enable
- req_addr  input  3*ADDR_W  per-port bank-local address, port i in slice i
- req_wdata  input  3*DATA_W  per-port write data
- req_tag  input  3*TAG_W  per-port request tag
- req_ready  output  3  per-port accept, combinational
- bank_en  output  1  bank access strobe, registered
- bank_wen  output  1  bank write enable, registered
- bank_addr  output  ADDR_W  bank address, registered
- bank_wdata  output  DATA_W  bank write data, registered
- bank_rdata  input  DATA_W  bank read data, valid one cycle after bank_en
- resp_valid  output  1  response strobe
- resp_port  output  3  one-hot originating port
- resp_wen  output  1  1 = write acknowledge, 0 = read data
- resp_tag  output  TAG_W  tag of the completed request
- resp_rdata  output  DATA_W  read data; 0 for writes

Behaviour:
- Reset (async assert, sync release): bank_en=0, bank_wen=0, bank_addr=0, bank_wdata=0, resp_valid=0, resp_port=0, resp_wen=0, resp_tag=0, priority pointer=port1 (ptr=0). In-flight accesses are discarded; no response is produced for them.
- Arbitration (combinational): search req_valid starting at ptr, then ptr+1, ptr+2 (mod 3). The first set bit wins; req_ready is one-hot on the winner only. All-zero req_valid -> req_ready=0.
- Handshake: a request is accepted when req_valid&req_ready. An unaccepted requester holds valid, wen, addr, wdata and tag stable until accepted. req_ready does not depend on any downstream backpressure; the arbiter never stalls itself.
- Pointer: on accept of port k, ptr <= (k+1) mod 3. With no accept, ptr holds. Wrap: port3 grant -> ptr=0.
- Stage 1 (edge after accept, cycle N+1): bank_en=1; bank_wen, bank_addr and bank_wdata take the winner's fields. Latched with the command: port one-hot, tag and wen.
- Stage 2 (cycle N+2):
  - resp_valid=1; resp_port, resp_tag and resp_wen come from the stage-1 latch.
  - Read: resp_rdata=bank_rdata, a combinational passthrough gated by resp_valid&~resp_wen.
  - Write: resp_rdata=0.
- Latency: accept cycle N -> response cycle N+2, fixed. Throughput: one access per cycle, so back-to-back grants give back-to-back responses.
- No accept in a cycle: the next cycle has bank_en=0 and its fields hold their previous values. The cycle after that has resp_valid=0.
- Fairness: with all three valid continuously, the grant order is 1,2,3,1,2,3,... No port waits more than 2 cycles once valid.
- Read-after-write to the same address on consecutive grants is ordered by the bank itself; the arbiter adds no forwarding.

Optional Feature:
- Macro BANK_ARB_STATS_EN.
- Defined: adds output conflict_cnt (16 bits) and input stats_clr (1 bit).
  - conflict_cnt increments on every cycle with two or more req_valid bits set.
  - It saturates at 16'hFFFF.
  - stats_clr synchronously zeroes it; clear has priority over increment.
  - Reset value is 0.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Shared package tpm_pkg holds: NUM_PORTS=3, ADDR_W, DATA_W, TAG_W, BANK_ID_W=2, bank read latency constant=1, and a typedef for the request struct (valid, wen, addr, wdata, tag).
- One natural sub-module: rr_arbiter3, the pure round-robin grant logic. Inputs are req[2:0] and ptr[1:0]; the output is a one-hot grant. It is combinational and reused by other shared resources.

Test Plan:
- Single read: port2 read at addr 10'h005, tag 2'b10; bank returns 16'hBEEF -> bank_en at N+1; resp_valid, resp_port=3'b010, resp_tag=2'b10 and resp_rdata=16'hBEEF at N+2.
- Three-way conflict: all ports valid from reset, held for 6 cycles -> grants 1,2,3,1,2,3. Each non-granted port sees req_ready=0 and keeps its request stable.
- Write ack: port3 write addr 10'h3FF, data 16'h1234, tag 2'b01 -> bank_wen=1, bank_wdata=16'h1234 at N+1; at N+2, resp_wen=1, resp_rdata=0, resp_tag=2'b01.
- Pointer wrap and idle: grant port3, then 2 idle cycles, then ports 1 and 3 valid -> port1 wins (ptr=0). Idle cycles show bank_en=0 and resp_valid=0.
- Reset mid-flight: assert rst_n=0 one cycle after an accept -> bank_en and resp_valid drop immediately and no response appears after release. The first post-reset conflict between ports 2 and 3 grants port2.
- BANK_ARB_STATS_EN: 5 cycles with two or more requests, then stats_clr together with a conflict -> conflict_cnt=5, then 0. A preload-to-saturation run holds conflict_cnt at 16'hFFFF.
